// File: rtl/rect_envelope_avg_if.sv
// Stream bus for the envelope averager: sample input, average output, flush and status.
interface rect_envelope_avg_if #(
  parameter int unsigned N = 16
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         clear;
  logic         primed;

  // Upstream/downstream side that drives samples, accepts averages and issues flushes
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready,
    output clear,
    input  primed
  );

  // Averager side
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready,
    input  clear,
    output primed
  );
endinterface

// File: rtl/rect_envelope_avg.sv
// Boxcar moving average of 2^LOG2W rectified samples with a single output slot,
// valid/ready handshakes on both sides and a synchronous flush that re-zeroes the window.
module rect_envelope_avg #(
  parameter int unsigned N     = 16,
  parameter int unsigned LOG2W = 3
) (
  input  logic                clk,
  input  logic                rst,
  rect_envelope_avg_if.slave  bus
);

  localparam int unsigned W  = 1 << LOG2W;
  localparam int unsigned SW = N + LOG2W;
  localparam int unsigned CW = LOG2W + 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LOG2W-1:0] wptr_q, wptr_d;
  logic [LOG2W-1:0] fidx_q, fidx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             primed_q, primed_d;
  logic [N-1:0]     win_q [W];

  logic             win_we;
  logic [LOG2W-1:0] win_waddr;
  logic [N-1:0]     win_wdata;

  logic             in_ready_c;
  logic             accept_c;
  logic [SW-1:0]    sum_acc_c;

  // Ready only when not flushing, not being cleared, and the output slot can take a result
  assign in_ready_c = !rst && (state_q != S_FLUSH) && !bus.clear &&
                      (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;
  // Running sum with the oldest entry swapped out for the new sample
  assign sum_acc_c  = sum_q + SW'(bus.in_data) - SW'(win_q[wptr_q]);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.primed    = primed_q;

  // Next-state, window write port and output slot
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    fidx_d      = fidx_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    primed_d    = primed_q;
    win_we      = 1'b0;
    win_waddr   = wptr_q;
    win_wdata   = bus.in_data;

    if (bus.clear) begin
      // Discard everything and restart zeroing the window from entry 0
      state_d     = S_FLUSH;
      fidx_d      = '0;
      wptr_d      = '0;
      cnt_d       = '0;
      sum_d       = '0;
      out_valid_d = 1'b0;
      primed_d    = 1'b0;
    end else begin
      case (state_q)
        S_FLUSH: begin
          win_we    = 1'b1;
          win_waddr = fidx_q;
          win_wdata = '0;
          fidx_d    = fidx_q + LOG2W'(1);
          if (fidx_q == LOG2W'(W - 1)) begin
            state_d = S_FILL;
          end
        end
        S_FILL: begin
          if (accept_c) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
              state_d  = S_RUN;
              primed_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          primed_d = 1'b1;
        end
        default: begin
          state_d = S_FILL;
        end
      endcase

      if (accept_c) begin
        win_we      = 1'b1;
        win_waddr   = wptr_q;
        win_wdata   = bus.in_data;
        sum_d       = sum_acc_c;
        wptr_d      = wptr_q + LOG2W'(1);
        out_data_d  = N'(sum_acc_c >> LOG2W);
        out_valid_d = 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FILL;
      wptr_q      <= '0;
      fidx_q      <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      fidx_q      <= fidx_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      primed_q    <= primed_d;
    end
  end

  // Sample window storage, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(W); i++) begin
        win_q[i] <= '0;
      end
    end else if (win_we) begin
      win_q[win_waddr] <= win_wdata;
    end
  end

endmodule
